bus_cs_reader: RTL



---
 rtl/bus_cs_reader_pkg.sv | 13 +
 rtl/bus_settle_counter.sv | 27 ++
 rtl/bus_cs_reader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bus_cs_reader_pkg.sv
// Shared definitions for the chip-select bus reader: FSM encoding and settle-counter sizing.
package bus_cs_reader_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam int unsigned MaxSettle = 15;
  localparam int unsigned CntWidth  = 4;

endpackage

// File: rtl/bus_settle_counter.sv
// Loadable down-counter for the settle window; advances only on enabled edges, stops at zero.
module bus_settle_counter
  import bus_cs_reader_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                i_load,
  input  logic [CntWidth-1:0] i_load_val,
  input  logic                i_tick,
  output logic                o_zero
);

  logic [CntWidth-1:0] r_count;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_cs_reader.sv
// Read master for the chip-selected tri-state bus: select, settle, sample, respond.
module bus_cs_reader
  import bus_cs_reader_pkg::*;
#(
  parameter int unsigned NrOfBits     = 32,
  parameter int unsigned NrOfSources  = 4,
  parameter int unsigned SelBits      = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Tick,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [SelBits-1:0]     ReqSel,
  output logic [NrOfSources-1:0] cs,
  input  logic [NrOfBits-1:0]    Bus,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [NrOfBits-1:0]    RspData,
  output logic [SelBits-1:0]     RspSel,
  output logic                   RspErr
);

  localparam logic [CntWidth-1:0] SettleLoad =
      CntWidth'((SettleCycles > MaxSettle) ? MaxSettle : SettleCycles);

  state_e                 r_state;
  logic [NrOfSources-1:0] r_cs;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic [NrOfBits-1:0]    r_rsp_data;
  logic [SelBits-1:0]     r_rsp_sel;
  logic                   r_rsp_err;

  logic                   w_in_range;
  logic                   w_accept;
  logic                   w_cnt_load;
  logic                   w_cnt_tick;
  logic                   w_cnt_zero;
  logic [NrOfSources-1:0] w_cs_sel;

  assign w_in_range = (32'(ReqSel) < NrOfSources);
  assign w_accept   = (r_state == StIdle) && r_req_ready && ReqValid;
  assign w_cnt_load = w_accept && w_in_range;
  assign w_cnt_tick = (r_state == StSelect) && Tick;

  // One-hot-low decode of the requested source.
  always_comb begin
    w_cs_sel = '1;
    for (int i = 0; i < NrOfSources; i++) begin
      if (32'(ReqSel) == i) w_cs_sel[i] = 1'b0;
    end
  end

  bus_settle_counter u_settle (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (SettleLoad),
    .i_tick     (w_cnt_tick),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= StIdle;
      r_cs        <= '1;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_sel   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rsp_sel   <= ReqSel;
            if (w_in_range) begin
              r_cs    <= w_cs_sel;
              r_state <= StSelect;
            end else begin
              // Out-of-range index: answer with an error, never touch the bus.
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end
          end
        end
        StSelect: begin
          if (Tick && w_cnt_zero) begin
            r_rsp_data  <= Bus;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cs        <= '1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (RspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cs       = r_cs;
  assign ReqReady = r_req_ready;
  assign RspValid = r_rsp_valid;
  assign RspData  = r_rsp_data;
  assign RspSel   = r_rsp_sel;
  assign RspErr   = r_rsp_err;

endmodule
